// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared types and geometry for the LED-matrix frame loader.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_FLIP = 2'd2
    } loader_state_t;

    localparam int ROWS            = 8;
    localparam int COLUMNS         = 32;
    localparam int PIXEL_WIDTH     = 24;
    localparam int BYTES_PER_PIXEL = PIXEL_WIDTH / 8;

endpackage

`default_nettype wire

// File: rtl/display_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : display_pixel_packer
// Purpose  : Packs an MSB-first byte stream into pixels, strobing each pixel.
// Revision : 1.0 - initial release
// ============================================================================
module display_pixel_packer
    import display_pkg::*;
#(
    parameter int PIX_WIDTH = PIXEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [7:0]           data,
    output logic [PIX_WIDTH-1:0] pixel,
    output logic                 pixel_done
);

    localparam int c_bpp     = PIX_WIDTH / 8;
    localparam int c_cntbits = (c_bpp > 1) ? $clog2(c_bpp) : 1;
    localparam logic [c_cntbits-1:0] c_last = c_cntbits'(c_bpp - 1);

    logic [c_cntbits-1:0] r_count;
    logic [c_cntbits-1:0] w_count;

    // clear together with shift restarts the pixel with this byte as byte 0
    assign w_count    = clear ? '0 : r_count;
    assign pixel_done = shift && (w_count == c_last);

    generate
        if (c_bpp > 1) begin : g_multi
            logic [PIX_WIDTH-9:0] r_acc;

            assign pixel = {r_acc, data};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (shift) begin
                    r_acc <= pixel[PIX_WIDTH-9:0];
                end
            end
        end else begin : g_single
            assign pixel = data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (shift) begin
            r_count <= pixel_done ? '0 : w_count + 1'b1;
        end else if (clear) begin
            r_count <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : display_frame_loader
// Purpose  : Loads SPI byte frames into the back buffer and flips buffers.
// Revision : 1.0 - initial release
// ============================================================================
module display_frame_loader
    import display_pkg::*;
#(
    parameter int NUM_ROWS    = ROWS,
    parameter int NUM_COLUMNS = COLUMNS,
    parameter int PIX_WIDTH   = PIXEL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     data,
    input  logic                           valid,
    input  logic                           sot,
    input  logic                           eot,
    input  logic                           safe_flip,
    output logic                           wen,
    output logic [$clog2(NUM_ROWS)-1:0]    wrow,
    output logic [$clog2(NUM_COLUMNS)-1:0] wcol,
    output logic [PIX_WIDTH-1:0]           wdata,
    output logic                           flip,
    output logic                           busy,
    output logic                           frame_err
);

    localparam int c_rowbits = $clog2(NUM_ROWS);
    localparam int c_colbits = $clog2(NUM_COLUMNS);
    localparam logic [c_rowbits-1:0] c_last_row = c_rowbits'(NUM_ROWS - 1);
    localparam logic [c_colbits-1:0] c_last_col = c_colbits'(NUM_COLUMNS - 1);

    loader_state_t        r_state, w_state;
    logic [c_rowbits-1:0] r_row, w_row, w_row_base;
    logic [c_colbits-1:0] r_col, w_col, w_col_base;
    logic                 r_tail, w_tail;       // frame complete, transfer still open
    logic                 r_overrun, w_overrun; // extra bytes seen in that tail
    logic                 r_drop, w_drop;       // discarding a rejected transfer
    logic                 w_wen, w_flip, w_err, w_track;
    logic [c_rowbits-1:0] w_wrow;
    logic [c_colbits-1:0] w_wcol;
    logic [PIX_WIDTH-1:0] w_wdata;
    logic                 w_start, w_clear, w_shift;
    logic                 w_pixel_done, w_frame_done;
    logic [PIX_WIDTH-1:0] w_pixel;

    assign w_start = valid && sot;

    display_pixel_packer #(
        .PIX_WIDTH (PIX_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .shift      (w_shift),
        .data       (data),
        .pixel      (w_pixel),
        .pixel_done (w_pixel_done)
    );

    // byte acceptance is decoded apart from the FSM to keep the packer path acyclic
    always_comb begin
        w_shift = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_drop && w_start) begin
                    w_shift = 1'b1;
                    w_clear = 1'b1;
                end
            end
            LOAD: begin
                w_shift = valid;
                w_clear = w_start;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_tail       = r_tail;
        w_overrun    = r_overrun;
        w_drop       = r_drop;
        w_wen        = 1'b0;
        w_wrow       = wrow;
        w_wcol       = wcol;
        w_wdata      = wdata;
        w_flip       = flip;
        w_err        = 1'b0;
        w_track      = 1'b0;
        w_row_base   = w_clear ? '0 : r_row;
        w_col_base   = w_clear ? '0 : r_col;
        w_row        = w_row_base;
        w_col        = w_col_base;
        w_frame_done = w_pixel_done && (w_row_base == c_last_row) && (w_col_base == c_last_col);

        if (w_pixel_done) begin
            w_wen   = 1'b1;
            w_wrow  = w_row_base;
            w_wcol  = w_col_base;
            w_wdata = w_pixel;
            if (w_frame_done) begin
                w_row = '0;
                w_col = '0;
            end else if (w_col_base == c_last_col) begin
                w_row = w_row_base + 1'b1;
                w_col = '0;
            end else begin
                w_col = w_col_base + 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (!r_drop && w_start) begin
                    w_state   = LOAD;
                    w_tail    = 1'b0;
                    w_overrun = 1'b0;
                end else begin
                    w_track = 1'b1;
                end
            end
            LOAD: begin
                if (w_frame_done) begin
                    w_state   = WAIT_FLIP;
                    w_tail    = !eot;
                    w_overrun = 1'b0;
                end else if (eot) begin
                    w_state = IDLE;
                    w_err   = 1'b1;
                end
            end
            WAIT_FLIP: begin
                if (safe_flip) begin
                    w_flip  = !flip;
                    w_state = IDLE;
                end
                if (!r_drop && w_start) begin
                    w_drop    = !eot;
                    w_err     = 1'b1;
                    w_tail    = 1'b0;
                    w_overrun = 1'b0;
                end else begin
                    w_track = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        // bytes after a complete frame are only judged when the transfer ends
        if (w_track) begin
            if (r_drop) begin
                if (eot) begin
                    w_drop = 1'b0;
                end
            end else if (r_tail) begin
                if (valid) begin
                    w_overrun = 1'b1;
                end
                if (eot) begin
                    w_err     = r_overrun || valid;
                    w_tail    = 1'b0;
                    w_overrun = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_tail    <= 1'b0;
            r_overrun <= 1'b0;
            r_drop    <= 1'b0;
            wen       <= 1'b0;
            wrow      <= '0;
            wcol      <= '0;
            wdata     <= '0;
            flip      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_row     <= w_row;
            r_col     <= w_col;
            r_tail    <= w_tail;
            r_overrun <= w_overrun;
            r_drop    <= w_drop;
            wen       <= w_wen;
            wrow      <= w_wrow;
            wcol      <= w_wcol;
            wdata     <= w_wdata;
            flip      <= w_flip;
            busy      <= (w_state != IDLE);
            frame_err <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_frame_loader
// Purpose  : Randomized self-checking bench against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_frame_loader;
    import display_pkg::*;

    localparam int c_npix        = ROWS * COLUMNS;
    localparam int c_frame_bytes = c_npix * BYTES_PER_PIXEL;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        valid, sot, eot, safe_flip;
    logic        wen;
    logic [2:0]  wrow;
    logic [4:0]  wcol;
    logic [23:0] wdata;
    logic        flip, busy, frame_err;

    always #5 clk = ~clk;

    display_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .valid     (valid),
        .sot       (sot),
        .eot       (eot),
        .safe_flip (safe_flip),
        .wen       (wen),
        .wrow      (wrow),
        .wcol      (wcol),
        .wdata     (wdata),
        .flip      (flip),
        .busy      (busy),
        .frame_err (frame_err)
    );

    typedef struct packed {
        logic [2:0]  row;
        logic [4:0]  col;
        logic [23:0] pix;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  act_q[$];
    int   err_pulses = 0;
    int   flip_toggles = 0;
    int   wen_b2b = 0;
    logic prev_flip = 1'b0;
    logic prev_wen = 1'b0;
    int   m_bytes = 0;
    int   m_pix = 0;
    logic [23:0] m_acc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wen) act_q.push_back(wr_t'({wrow, wcol, wdata}));
        if (frame_err) err_pulses++;
        if (flip !== prev_flip) flip_toggles++;
        if (wen && prev_wen) wen_b2b++;
        prev_flip = flip;
        prev_wen  = wen;
    end

    // Reference: pixel k of a frame = bytes 3k..3k+2 MSB first, at (k / COLUMNS, k % COLUMNS)
    task automatic model_byte(input logic [7:0] b, input bit first, input bit accept);
        if (!accept) return;
        if (first) begin
            m_bytes = 0;
            m_pix   = 0;
        end
        m_acc = {m_acc[15:0], b};
        m_bytes++;
        if (m_bytes == BYTES_PER_PIXEL) begin
            m_bytes = 0;
            if (m_pix < c_npix)
                exp_q.push_back(wr_t'({3'(m_pix / COLUMNS), 5'(m_pix % COLUMNS), m_acc}));
            m_pix++;
        end
    endtask

    task automatic send_frame(input int n, input int gmin, input int gmax, input bit incr,
                              input bit with_sot, input bit accept, input bit eot_last);
        logic [7:0] b;
        int gap;
        for (int i = 0; i < n; i++) begin
            b     = incr ? 8'(i) : 8'($urandom);
            gap   = $urandom_range(gmax, gmin);
            data  = b;
            valid = 1'b1;
            sot   = with_sot && (i == 0);
            eot   = eot_last && (i == n - 1);
            model_byte(b, i == 0, accept);
            @(posedge clk); #1;
            valid = 1'b0;
            sot   = 1'b0;
            eot   = 1'b0;
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_eot();
        eot = 1'b1;
        @(posedge clk); #1;
        eot = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(tag, busy, 1'b0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic start_scenario();
        @(negedge clk); #1;
        act_q.delete();
        exp_q.delete();
        err_pulses   = 0;
        flip_toggles = 0;
        wen_b2b      = 0;
        m_bytes      = 0;
        m_pix        = 0;
    endtask

    initial begin
        logic flip_before;
        int   hold_bad;

        rst = 1'b1; data = '0; valid = 1'b0; sot = 1'b0; eot = 1'b0; safe_flip = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wen", wen, 0);
        check("rst_wrow", wrow, 0);
        check("rst_wcol", wcol, 0);
        check("rst_wdata", wdata, 0);
        check("rst_flip", flip, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // stray bytes without sot in IDLE are ignored
        start_scenario();
        send_frame(7, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_writes", act_q.size(), 0);
        check("stray_err", err_pulses, 0);

        // incrementing full frame, one byte every 4 clocks
        start_scenario();
        send_frame(c_frame_bytes, 4, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        send_eot();
        wait_idle("inc_idle");
        if (act_q.size() > 1) begin
            check("inc_pix00", act_q[0].pix, 24'h000102);
            check("inc_pix01", act_q[1].pix, 24'h030405);
            check("inc_last_row", act_q[act_q.size()-1].row, 3'd7);
            check("inc_last_col", act_q[act_q.size()-1].col, 5'd31);
        end
        compare_writes("inc");
        check("inc_flip", flip, 1);
        check("inc_toggles", flip_toggles, 1);
        check("inc_err", err_pulses, 0);
        check("inc_b2b", wen_b2b, 0);

        // asynchronous reset mid-frame after 100 bytes
        start_scenario();
        send_frame(100, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        compare_writes("pre_rst");
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_wen", wen, 0);
        check("arst_wrow", wrow, 0);
        check("arst_wcol", wcol, 0);
        check("arst_wdata", wdata, 0);
        check("arst_flip", flip, 0);
        check("arst_busy", busy, 0);
        check("arst_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_scenario();
        send_frame(c_frame_bytes, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        wait_idle("post_rst_idle");
        compare_writes("post_rst");
        check("post_rst_flip", flip, 1);
        check("post_rst_toggles", flip_toggles, 1);

        // flip held off by safe_flip
        start_scenario();
        safe_flip = 1'b0;
        flip_before = flip;
        send_frame(c_frame_bytes, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || flip !== flip_before) hold_bad++;
        end
        check("hold_stable", hold_bad, 0);
        @(posedge clk); #1;
        safe_flip = 1'b1;
        @(negedge clk);
        check("hold_flip_early", flip, flip_before);
        @(posedge clk); #1;
        check("hold_flip_after", flip, !flip_before);
        check("hold_busy_after", busy, 0);
        compare_writes("hold");
        check("hold_err", err_pulses, 0);

        // short frame
        start_scenario();
        flip_before = flip;
        send_frame(300, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        wait_idle("short_idle");
        compare_writes("short");
        check("short_flip", flip, flip_before);
        check("short_err", err_pulses, 1);

        // overlong frame
        start_scenario();
        send_frame(c_frame_bytes + 3, 1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        wait_idle("long_idle");
        compare_writes("long");
        check("long_err", err_pulses, 1);
        check("long_toggles", flip_toggles, 1);

        // second frame during WAIT_FLIP is dropped
        start_scenario();
        safe_flip = 1'b0;
        send_frame(c_frame_bytes, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        send_frame(c_frame_bytes, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        send_eot();
        check("drop_busy", busy, 1);
        safe_flip = 1'b1;
        wait_idle("drop_idle");
        compare_writes("drop");
        check("drop_err", err_pulses, 1);
        check("drop_toggles", flip_toggles, 1);

        // eot together with the last byte
        start_scenario();
        send_frame(c_frame_bytes, 1, 3, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        wait_idle("eotlast_idle");
        compare_writes("eotlast");
        check("eotlast_err", err_pulses, 0);
        check("eotlast_toggles", flip_toggles, 1);

        // sot mid-frame restarts at pixel 0
        start_scenario();
        send_frame(50, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(c_frame_bytes, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        send_eot();
        wait_idle("restart_idle");
        compare_writes("restart");
        check("restart_err", err_pulses, 0);
        check("restart_toggles", flip_toggles, 1);
        check("restart_b2b", wen_b2b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
